frwd_bypass_net: RTL and testbench

- Parametrised successor to the ALU operand-forwarding mux.
- Keeps its own pipeline of in-flight destination tags instead of taking per-path forward strobes from outside. It generates priority bypass selects across DEPTH result stages, and it detects load-use hazards itself, raising a stall and inserting a bubble.
- Sits at the ID/EX boundary. Operands are combinational and are captured by the ID/EX register. It also keeps a saturating stall counter for performance monitoring.

---
 rtl/frwd_bypass_net_if.sv | 43 ++++
 rtl/frwd_bypass_net.sv | 128 ++++++++++++
 tb/tb_frwd_bypass_net.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/frwd_bypass_net_if.sv
// ID-stage side of the operand bypass network: decode fields, register-file data,
// stage results in; ALU operands, stall request and stall count out.
interface frwd_bypass_net_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int DEPTH   = 3,
    parameter int CNT_W   = 16
);
    logic                     i_issue_valid;
    logic [RADDR_W-1:0]       i_rd;
    logic                     i_rd_we;
    logic                     i_is_load;
    logic [RADDR_W-1:0]       i_rs1;
    logic [RADDR_W-1:0]       i_rs2;
    logic                     i_rs1_used;
    logic                     i_rs2_used;
    logic [XLEN-1:0]          i_rs1_rdata;
    logic [XLEN-1:0]          i_rs2_rdata;
    logic [XLEN-1:0]          i_pc;
    logic                     i_auipc;
    logic                     i_link;
    logic [DEPTH*XLEN-1:0]    i_stage_res;
    logic                     i_hold;
    logic                     i_flush;
    logic [XLEN-1:0]          o_op1;
    logic [XLEN-1:0]          o_op2;
    logic                     o_stall;
    logic [CNT_W-1:0]         o_stall_cnt;

    modport master (
        output i_issue_valid, i_rd, i_rd_we, i_is_load, i_rs1, i_rs2,
               i_rs1_used, i_rs2_used, i_rs1_rdata, i_rs2_rdata, i_pc,
               i_auipc, i_link, i_stage_res, i_hold, i_flush,
        input  o_op1, o_op2, o_stall, o_stall_cnt
    );

    modport slave (
        input  i_issue_valid, i_rd, i_rd_we, i_is_load, i_rs1, i_rs2,
               i_rs1_used, i_rs2_used, i_rs1_rdata, i_rs2_rdata, i_pc,
               i_auipc, i_link, i_stage_res, i_hold, i_flush,
        output o_op1, o_op2, o_stall, o_stall_cnt
    );
endinterface

// File: rtl/frwd_bypass_net.sv
// ID/EX operand bypass network: tracks in-flight destination tags, picks the youngest
// matching stage per source, and raises a load-use stall when that stage has no data yet.

module frwd_src_sel #(
    parameter int XLEN     = 32,
    parameter int RADDR_W  = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2
) (
    input  logic                          used,
    input  logic [RADDR_W-1:0]            idx,
    input  logic [DEPTH-1:0]              tag_vld,
    input  logic [DEPTH-1:0]              tag_ld,
    input  logic [DEPTH-1:0][RADDR_W-1:0] tag_rd,
    input  logic [DEPTH-1:0][XLEN-1:0]    stage_res,
    output logic                          hit,
    output logic                          not_rdy,
    output logic [XLEN-1:0]               fwd_data
);
    logic [DEPTH-1:0] match;

    always_comb begin
        match = '0;
        for (int k = 0; k < DEPTH; k++)
            match[k] = used && tag_vld[k] && (tag_rd[k] == idx) && (idx != '0);
    end

    // Walk oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hit      = 1'b0;
        not_rdy  = 1'b0;
        fwd_data = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match[k]) begin
                hit      = 1'b1;
                not_rdy  = tag_ld[k] && (k < LOAD_LAT);
                fwd_data = stage_res[k];
            end
        end
    end
endmodule

module frwd_bypass_net #(
    parameter int XLEN     = 32,
    parameter int RADDR_W  = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    frwd_bypass_net_if.slave   bus
);
    localparam int NUM_SRC = 2;
    localparam logic [XLEN-1:0] LINK_OFS = XLEN'(4);

    // Tag pipe, entry 0 = EX (youngest)
    logic [DEPTH-1:0]              vld_pipe;
    logic [DEPTH-1:0]              ld_pipe;
    logic [DEPTH-1:0][RADDR_W-1:0] rd_pipe;
    logic [CNT_W-1:0]              stall_cnt;

    logic [DEPTH-1:0][XLEN-1:0]    stage_res;
    logic [NUM_SRC-1:0]            src_used;
    logic [NUM_SRC-1:0][RADDR_W-1:0] src_idx;
    logic [NUM_SRC-1:0]            src_hit;
    logic [NUM_SRC-1:0]            src_nrdy;
    logic [NUM_SRC-1:0][XLEN-1:0]  src_fwd;
    logic [NUM_SRC-1:0]            use_fwd;
    logic                          stall;
    logic                          push;

    assign stage_res = bus.i_stage_res;
    assign src_used  = {bus.i_rs2_used, bus.i_rs1_used};
    assign src_idx   = {bus.i_rs2, bus.i_rs1};

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        frwd_src_sel #(
            .XLEN     (XLEN),
            .RADDR_W  (RADDR_W),
            .DEPTH    (DEPTH),
            .LOAD_LAT (LOAD_LAT)
        ) u_sel (
            .used      (src_used[g]),
            .idx       (src_idx[g]),
            .tag_vld   (vld_pipe),
            .tag_ld    (ld_pipe),
            .tag_rd    (rd_pipe),
            .stage_res (stage_res),
            .hit       (src_hit[g]),
            .not_rdy   (src_nrdy[g]),
            .fwd_data  (src_fwd[g])
        );
        assign use_fwd[g] = src_hit[g] && !src_nrdy[g];
    end

    // A flushed instruction never stalls; it just becomes a bubble.
    assign stall = bus.i_issue_valid && !bus.i_flush && |(src_hit & src_nrdy);
    assign push  = bus.i_issue_valid && bus.i_rd_we && !stall && !bus.i_flush;

    always_comb begin
        bus.o_op1 = use_fwd[0] ? src_fwd[0] : (bus.i_auipc ? bus.i_pc : bus.i_rs1_rdata);
        bus.o_op2 = use_fwd[1] ? src_fwd[1] : (bus.i_link  ? LINK_OFS : bus.i_rs2_rdata);
    end

    assign bus.o_stall     = stall;
    assign bus.o_stall_cnt = stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe  <= '0;
            ld_pipe   <= '0;
            rd_pipe   <= '0;
            stall_cnt <= '0;
        end else if (!bus.i_hold) begin
            for (int k = 1; k < DEPTH; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                ld_pipe[k]  <= ld_pipe[k-1];
                rd_pipe[k]  <= rd_pipe[k-1];
            end
            vld_pipe[0] <= push;
            ld_pipe[0]  <= bus.i_is_load;
            rd_pipe[0]  <= bus.i_rd;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_frwd_bypass_net.sv
// Directed bench for frwd_bypass_net (DEPTH=3, LOAD_LAT=2, CNT_W=4 to reach saturation).
module tb_frwd_bypass_net;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    frwd_bypass_net_if #(.XLEN(32), .RADDR_W(5), .DEPTH(3), .CNT_W(4)) bus ();

    frwd_bypass_net #(
        .XLEN(32), .RADDR_W(5), .DEPTH(3), .LOAD_LAT(2), .CNT_W(4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_issue_valid = 0; bus.i_rd = 0; bus.i_rd_we = 0; bus.i_is_load = 0;
        bus.i_rs1 = 0; bus.i_rs2 = 0; bus.i_rs1_used = 0; bus.i_rs2_used = 0;
        bus.i_auipc = 0; bus.i_link = 0; bus.i_hold = 0; bus.i_flush = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic ld);
        idle();
        bus.i_issue_valid = 1; bus.i_rd = rd; bus.i_rd_we = 1; bus.i_is_load = ld;
    endtask

    task automatic res(input logic [31:0] s2, input logic [31:0] s1, input logic [31:0] s0);
        bus.i_stage_res = {s2, s1, s0};
    endtask

    initial begin
        idle();
        bus.i_rs1_rdata = 32'hAAAA; bus.i_rs2_rdata = 32'h7777; bus.i_pc = 32'h100;
        res(32'h33, 32'h22, 32'h11);
        bus.i_rs1 = 5; bus.i_rs1_used = 1;
        #2;
        chk("reset_op1", bus.o_op1, 32'hAAAA);
        chk("reset_stall", {31'd0, bus.o_stall}, 32'd0);
        chk("reset_cnt", {28'd0, bus.o_stall_cnt}, 32'd0);
        #5 rst_n = 1'b1;

        // ALU-ALU back to back on x5
        tick(); issue(5, 0);
        tick(); idle();
        bus.i_issue_valid = 1; bus.i_rs1 = 5; bus.i_rs1_used = 1; bus.i_rs1_rdata = 32'hBAD;
        #1;
        chk("alu_op1_s0", bus.o_op1, 32'h11);
        chk("alu_stall", {31'd0, bus.o_stall}, 32'd0);
        chk("alu_op2_rf", bus.o_op2, 32'h7777);
        tick(); chk("alu_op1_s1", bus.o_op1, 32'h22);
        bus.i_issue_valid = 0;
        tick(); chk("alu_op1_s2", bus.o_op1, 32'h33);
        tick(); chk("alu_op1_rf", bus.o_op1, 32'hBAD);

        // Load-use on x6 via rs2
        issue(6, 1);
        tick(); issue(9, 0);
        bus.i_rs2 = 6; bus.i_rs2_used = 1; bus.i_rs2_rdata = 32'h5555;
        res(32'hDEAD, 32'hBEEF, 32'hCAFE);
        #1;
        chk("lu_stall_c1", {31'd0, bus.o_stall}, 32'd1);
        chk("lu_cnt_c1", {28'd0, bus.o_stall_cnt}, 32'd0);
        tick();
        chk("lu_stall_c2", {31'd0, bus.o_stall}, 32'd1);
        chk("lu_cnt_c2", {28'd0, bus.o_stall_cnt}, 32'd1);
        tick();
        chk("lu_stall_c3", {31'd0, bus.o_stall}, 32'd0);
        chk("lu_op2_s2", bus.o_op2, 32'hDEAD);
        chk("lu_cnt_c3", {28'd0, bus.o_stall_cnt}, 32'd2);
        tick(); idle();
        bus.i_rs1 = 9; bus.i_rs1_used = 1;
        #1;
        chk("lu_issued_x9", bus.o_op1, 32'hCAFE);
        chk("lu_cnt_after", {28'd0, bus.o_stall_cnt}, 32'd2);

        // Youngest wins: x7 in stage 2 and stage 0
        issue(7, 0); tick();
        idle(); tick();
        issue(7, 0); tick();
        idle(); bus.i_issue_valid = 1; bus.i_rs1 = 7; bus.i_rs1_used = 1;
        res(32'h1, 32'h99, 32'h2);
        #1;
        chk("young_op1", bus.o_op1, 32'h2);
        chk("young_stall", {31'd0, bus.o_stall}, 32'd0);

        // Same with stage 0 a load: stall even though stage 2 is ready
        issue(7, 0); tick();
        idle(); tick();
        issue(7, 1); tick();
        idle(); bus.i_issue_valid = 1; bus.i_rs1 = 7; bus.i_rs1_used = 1;
        #1;
        chk("young_ld_stall", {31'd0, bus.o_stall}, 32'd1);

        // Hold during stall: nothing moves, no counting
        bus.i_hold = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_stall", {31'd0, bus.o_stall}, 32'd1);
            chk("hold_cnt", {28'd0, bus.o_stall_cnt}, 32'd2);
        end

        // Flush beats the hazard; entry 0 becomes a bubble
        bus.i_hold = 0; bus.i_flush = 1; bus.i_rd = 8; bus.i_rd_we = 1;
        #1;
        chk("flush_stall", {31'd0, bus.o_stall}, 32'd0);
        tick(); idle();
        bus.i_issue_valid = 1; bus.i_rs2 = 8; bus.i_rs2_used = 1; bus.i_rs2_rdata = 32'h8888;
        #1;
        chk("flush_bubble_op2", bus.o_op2, 32'h8888);
        chk("flush_cnt", {28'd0, bus.o_stall_cnt}, 32'd2);
        bus.i_rs1 = 7; bus.i_rs1_used = 1;
        #1;
        chk("flush_ld_in_s1", {31'd0, bus.o_stall}, 32'd1);

        // x0 and unused sources
        issue(0, 0); tick();
        idle(); bus.i_issue_valid = 1;
        bus.i_rs1 = 0; bus.i_rs1_used = 1; bus.i_rs1_rdata = 32'h1234;
        bus.i_rs2 = 7; bus.i_rs2_used = 0; bus.i_link = 1;
        #1;
        chk("x0_op1_rf", bus.o_op1, 32'h1234);
        chk("x0_stall", {31'd0, bus.o_stall}, 32'd0);
        chk("jal_op2_4", bus.o_op2, 32'd4);
        bus.i_rs1_used = 0; bus.i_auipc = 1; bus.i_pc = 32'h100;
        #1;
        chk("auipc_op1_pc", bus.o_op1, 32'h100);

        // Asynchronous reset with a pending load-use hazard on x5
        issue(5, 1); tick();
        idle(); bus.i_issue_valid = 1; bus.i_rs1 = 5; bus.i_rs1_used = 1; bus.i_rs1_rdata = 32'h4242;
        #1;
        chk("pre_rst_stall", {31'd0, bus.o_stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_op1", bus.o_op1, 32'h4242);
        chk("rst_stall", {31'd0, bus.o_stall}, 32'd0);
        chk("rst_cnt", {28'd0, bus.o_stall_cnt}, 32'd0);
        #1 rst_n = 1'b1;

        // Repeated lw x6,0(x6): 2 stall cycles per 3 after the first issue
        issue(6, 1); bus.i_rs1 = 6; bus.i_rs1_used = 1;
        for (int i = 0; i < 7; i++) tick();
        chk("sat_cnt_mid", {28'd0, bus.o_stall_cnt}, 32'd4);
        for (int i = 0; i < 24; i++) tick();
        chk("sat_cnt_15", {28'd0, bus.o_stall_cnt}, 32'd15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
